// File: rtl/arith_pkg.sv
// Shared arithmetic types and a reference full-adder function.
// Pure declarations; no logic or state.
package arith_pkg;

  // Two-bit result of a one-bit add: {carry, sum}.
  typedef logic [1:0] fa_result_t;

  function automatic fa_result_t fa_ref(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/full_adder1_half_adder.sv
// Half adder: s = x ^ y, c = x & y.
// Zero latency, purely combinational.
module half_adder
  import arith_pkg::*;
(
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  fa_result_t w_res;

  assign w_res = {x & y, x ^ y};
  assign s     = w_res[0];
  assign c     = w_res[1];

endmodule

// File: rtl/full_adder1.sv
// One-bit full adder built from two half adders, with optional registered copies.
// sum1/Cout: zero latency; sum1_q/Cout_q/valid_q: one cycle after a cycle with en=1.
module full_adder1
  import arith_pkg::*;
#(
  parameter bit   REG_OUT  = 1'b1,
  parameter logic RST_SUM  = 1'b0,
  parameter logic RST_COUT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic Cin,
  input  logic en,
  output logic sum1,
  output logic Cout,
  output logic sum1_q,
  output logic Cout_q,
  output logic valid_q
);

  logic       w_s1;
  logic       w_c1;
  logic       w_c2;
  fa_result_t w_res;

  half_adder u_ha0 (
    .x (a),
    .y (b),
    .s (w_s1),
    .c (w_c1)
  );

  half_adder u_ha1 (
    .x (w_s1),
    .y (Cin),
    .s (w_res[0]),
    .c (w_c2)
  );

  // The two half-adder carries can never both be 1, so OR is exact.
  assign w_res[1] = w_c1 | w_c2;
  assign sum1     = w_res[0];
  assign Cout     = w_res[1];

  if (REG_OUT) begin : g_reg
    logic r_sum;
    logic r_cout;
    logic r_vld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sum  <= RST_SUM;
        r_cout <= RST_COUT;
        r_vld  <= 1'b0;
      end else begin
        r_vld <= en;
        if (en) begin
          r_sum  <= w_res[0];
          r_cout <= w_res[1];
        end
      end
    end

    assign sum1_q  = r_sum;
    assign Cout_q  = r_cout;
    assign valid_q = r_vld;
  end else begin : g_noreg
    assign sum1_q  = 1'b0;
    assign Cout_q  = 1'b0;
    assign valid_q = 1'b0;
  end

endmodule

// File: tb/tb_full_adder1.sv
// Directed and random checks of full_adder1 combinational and registered outputs.
module tb_full_adder1;
  import arith_pkg::*;

  logic clk;
  logic rst;
  logic a;
  logic b;
  logic Cin;
  logic en;
  logic sum1;
  logic Cout;
  logic sum1_q;
  logic Cout_q;
  logic valid_q;

  int checks;
  int errors;

  full_adder1 #(
    .REG_OUT  (1'b1),
    .RST_SUM  (1'b0),
    .RST_COUT (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .Cin     (Cin),
    .en      (en),
    .sum1    (sum1),
    .Cout    (Cout),
    .sum1_q  (sum1_q),
    .Cout_q  (Cout_q),
    .valid_q (valid_q)
  );

  // One full clock period; outputs are sampled afterwards with clk low.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic test_reset();
    a = 1'b1; b = 1'b1; Cin = 1'b1; en = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({Cout, sum1} !== 2'b11) begin
      errors++;
      $display("FAIL reset_comb got %b%b want 11", Cout, sum1);
    end
    checks++;
    if ({valid_q, Cout_q, sum1_q} !== 3'b000) begin
      errors++;
      $display("FAIL reset_regs got v=%b c=%b s=%b want 000", valid_q, Cout_q, sum1_q);
    end
  endtask

  task automatic test_comb();
    // Rows {a,b,Cin,Cout,sum1}.
    logic [4:0] vec [8];
    vec[0] = 5'b000_00; vec[1] = 5'b100_01; vec[2] = 5'b010_01; vec[3] = 5'b110_10;
    vec[4] = 5'b001_01; vec[5] = 5'b101_10; vec[6] = 5'b011_10; vec[7] = 5'b111_11;
    for (int i = 0; i < 8; i++) begin
      {a, b, Cin} = vec[i][4:2];
      #10;
      checks++;
      if ({Cout, sum1} !== vec[i][1:0]) begin
        errors++;
        $display("FAIL comb_%b got %b%b want %b", vec[i][4:2], Cout, sum1, vec[i][1:0]);
      end
    end
  endtask

  task automatic test_capture();
    rst = 1'b0;
    en = 1'b1; a = 1'b1; b = 1'b0; Cin = 1'b1;
    tick();
    checks++;
    if ({valid_q, Cout_q, sum1_q} !== 3'b110) begin
      errors++;
      $display("FAIL capture got v=%b c=%b s=%b want 110", valid_q, Cout_q, sum1_q);
    end
  endtask

  task automatic test_hold();
    en = 1'b0; a = 1'b0; b = 1'b0; Cin = 1'b0;
    tick();
    checks++;
    if ({valid_q, Cout_q, sum1_q} !== 3'b010) begin
      errors++;
      $display("FAIL hold_regs got v=%b c=%b s=%b want 010", valid_q, Cout_q, sum1_q);
    end
    checks++;
    if ({Cout, sum1} !== 2'b00) begin
      errors++;
      $display("FAIL hold_comb got %b%b want 00", Cout, sum1);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; a = 1'b1; b = 1'b0; Cin = 1'b0;
    tick();
    checks++;
    if ({valid_q, Cout_q, sum1_q} !== 3'b101) begin
      errors++;
      $display("FAIL pre_async got v=%b c=%b s=%b want 101", valid_q, Cout_q, sum1_q);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({valid_q, Cout_q, sum1_q} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got v=%b c=%b s=%b want 000", valid_q, Cout_q, sum1_q);
    end
    // Reset held across an edge with en=1 must still win.
    tick();
    checks++;
    if ({valid_q, Cout_q, sum1_q} !== 3'b000) begin
      errors++;
      $display("FAIL reset_over_edge got v=%b c=%b s=%b want 000", valid_q, Cout_q, sum1_q);
    end
    rst = 1'b0;
    // First capture lands on the first edge after deassertion.
    a = 1'b1; b = 1'b1; Cin = 1'b0;
    tick();
    checks++;
    if ({valid_q, Cout_q, sum1_q} !== 3'b110) begin
      errors++;
      $display("FAIL first_capture got v=%b c=%b s=%b want 110", valid_q, Cout_q, sum1_q);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_c;
    logic [1:0] m_q;
    logic       m_v;
    m_q = 2'b10;
    m_v = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      Cin = 1'($urandom_range(0, 1));
      en  = 1'($urandom_range(0, 1));
      #1;
      exp_c = fa_ref(a, b, Cin);
      checks++;
      if ({Cout, sum1} !== exp_c) begin
        errors++;
        $display("FAIL rand_comb_%0d in=%b%b%b got %b%b want %b", i, a, b, Cin, Cout, sum1, exp_c);
      end
      if (en) m_q = 2'({1'b0, a} + {1'b0, b} + {1'b0, Cin});
      m_v = en;
      tick();
      checks++;
      if ({valid_q, Cout_q, sum1_q} !== {m_v, m_q}) begin
        errors++;
        $display("FAIL rand_reg_%0d got v=%b c=%b s=%b want %b", i, valid_q, Cout_q, sum1_q, {m_v, m_q});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0; rst = 1'b0; a = 1'b0; b = 1'b0; Cin = 1'b0; en = 1'b0;
    test_reset();
    test_comb();
    test_capture();
    test_hold();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
